sel_rr_arb_32x3: RTL and testbench
==================================

// Module: sel_rr_arb_32x3
//
// PURPOSE
//  Arbiter and output stage for a 3-source, 32-bit priority select path. It shares one 32-bit
//  result channel between three valid/ready requesters. It picks one winner per cycle, round-robin
//  or fixed priority, with optional burst locking. The winning beat is registered onto a single
//  out_valid/out_ready channel. Throughput is one beat per clock. Latency is 1 cycle from accept
//  to out_valid.
//
// PARAMETERS
//  WIDTH   32  data width of every source and of the output
//  RR_EN   1   1 = round-robin; 0 = fixed priority src0 > src1 > src2 (ptr stuck at 0, no burst lock)
//  BURST   1   max consecutive beats a winner keeps the grant while it stays valid (1..15); 1 = pure RR
//
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      asynchronous reset, active high
//  src0_valid in   1      source 0 beat valid
//  src0_data  in   WIDTH  source 0 payload
//  src0_ready out  1      source 0 beat accepted this cycle (when valid)
//  src1_*     same as src0_* for source 1
//  src2_*     same as src0_* for source 2
//  out_valid  out  1      registered beat valid
//  out_data   out  WIDTH  registered payload
//  out_sel    out  3      one-hot source of out_data
//  out_ready  in   1      downstream accepts out beat
//
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, out_data=0, out_sel=000, ptr=0, last_w=0, last_v=0, cnt=0.
//  Reset mid-operation drops any held beat; sources see ready=0 while reset is high.
//  can_acc = !out_valid | out_ready.
//  lock = RR_EN & last_v & (cnt < BURST-1) & src[last_w]_valid.
//  Winner w:
//   - if lock, w = last_w;
//   - else w = first valid source in order ptr, ptr+1, ptr+2 (mod 3).
//   - With RR_EN=0: w = lowest-index valid source.
//   - No source valid -> no winner.
//  srcN_ready = can_acc & (N == w); it is combinational from the valids and state.
//   - At most one ready is high per cycle.
//   - ready is never high for a non-winner.
//  Transfer = src[w]_valid & src[w]_ready. On transfer:
//   - out_valid <= 1, out_data <= src[w]_data, out_sel <= onehot(w).
//   - ptr <= (w+1) mod 3 when RR_EN=1.
//   - cnt <= (last_v & w == last_w) ? cnt+1 : 0; last_w <= w; last_v <= 1.
//  can_acc with no valid source:
//   - out_valid <= 0 if out_ready; last_v <= 0 (burst broken), cnt <= 0.
//  Stall (out_valid & !out_ready):
//   - out_* hold; all ready low; ptr/cnt/last_* hold.
//  out_data and out_sel hold their last value after the beat drains; they are 0 only after reset.
//  cnt is 4 bits and saturates at BURST-1; it never wraps.
//  ptr wraps 2 -> 0.
//  Simultaneous requests resolve in the same cycle. The lock holds only while the locked source
//  stays valid; a dropped valid releases it to RR order from ptr.
//  Source valid/data must stay stable until ready; sources may drop valid before ready without error.
//
// TESTING
//  1. Reset mid-stream with out_valid=1:
//     -> out_valid=0, out_sel=000, out_data=0 immediately.
//     -> First beat after release goes to src0 if all sources are valid.
//  2. RR_EN=1, BURST=1, all three valid, out_ready=1 for 6 cycles.
//     -> out_sel sequence 001,010,100,001,010,100, one beat per clock.
//     -> out_data matches each source's value, e.g. 0xA0000000/0xB1111111/0xC2222222.
//  3. RR_EN=0, all valid.
//     -> Only src0 granted every cycle; src1_ready and src2_ready stay 0.
//     -> Drop src0: src1 wins the next cycle.
//  4. out_ready=0 for 4 cycles with out_valid=1.
//     -> out_data/out_sel stable; all src*_ready=0; ptr unchanged.
//     -> On out_ready=1, the next winner follows the saved ptr.
//  5. RR_EN=1, BURST=3, all valid.
//     -> Grants 0,0,0,1,1,1,2,2,2,0.
//     -> src0 drops valid after 2 beats: src1 wins next, and cnt restarts at 0.
//  6. Single source src2 streaming 0..9 with random out_ready.
//     -> All 10 values seen in order, no duplicates or losses.
//     -> out_sel=100 throughout.

Source files
------------

// File: rtl/sel_rr_arb_32x3_if.sv
// rtl/sel_rr_arb_32x3_if.sv - three-source request bundle plus registered output channel
interface sel_rr_arb_32x3_if #(
  parameter int WIDTH = 32
);
  logic             src0_valid;
  logic [WIDTH-1:0] src0_data;
  logic             src0_ready;
  logic             src1_valid;
  logic [WIDTH-1:0] src1_data;
  logic             src1_ready;
  logic             src2_valid;
  logic [WIDTH-1:0] src2_data;
  logic             src2_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_sel;
  logic             out_ready;

  // Requesters and downstream sink side
  modport master (
    output src0_valid, src0_data, src1_valid, src1_data, src2_valid, src2_data, out_ready,
    input  src0_ready, src1_ready, src2_ready, out_valid, out_data, out_sel
  );

  // Arbiter side
  modport slave (
    input  src0_valid, src0_data, src1_valid, src1_data, src2_valid, src2_data, out_ready,
    output src0_ready, src1_ready, src2_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/sel_rr_arb_32x3.sv
// rtl/sel_rr_arb_32x3.sv - 3-way round-robin/fixed-priority arbiter with burst lock and registered output
module sel_rr_arb_32x3 #(
  parameter int WIDTH = 32,
  parameter int RR_EN = 1,
  parameter int BURST = 1
) (
  input logic             clk,
  input logic             reset,
  sel_rr_arb_32x3_if.slave bus
);
  localparam logic [3:0] BURST_M1 = 4'(BURST - 1);

  logic [2:0]       valid;
  logic [WIDTH-1:0] data [3];

  logic [1:0]       ptr;
  logic [1:0]       last_w;
  logic             last_v;
  logic [3:0]       cnt;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [2:0]       out_sel_q;

  logic             can_acc;
  logic             lock;
  logic             has_win;
  logic [1:0]       win;
  logic [1:0]       c1;
  logic [1:0]       c2;
  logic [2:0]       ready;
  logic [WIDTH-1:0] win_data;

  assign valid   = {bus.src2_valid, bus.src1_valid, bus.src0_valid};
  assign data[0] = bus.src0_data;
  assign data[1] = bus.src1_data;
  assign data[2] = bus.src2_data;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] p);
    case (p)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic valid_at(input logic [2:0] v, input logic [1:0] p);
    case (p)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  // Winner selection: burst lock first, otherwise first valid source scanning from ptr
  always_comb begin
    can_acc = !out_valid_q || bus.out_ready;
    lock    = (RR_EN != 0) && last_v && (cnt < BURST_M1) && valid_at(valid, last_w);
    c1      = nxt(ptr);
    c2      = nxt(c1);
    has_win = 1'b0;
    win     = ptr;
    if (lock) begin
      has_win = 1'b1;
      win     = last_w;
    end else if (valid_at(valid, ptr)) begin
      has_win = 1'b1;
      win     = ptr;
    end else if (valid_at(valid, c1)) begin
      has_win = 1'b1;
      win     = c1;
    end else if (valid_at(valid, c2)) begin
      has_win = 1'b1;
      win     = c2;
    end
    ready    = (can_acc && has_win && !reset) ? onehot(win) : 3'b000;
    win_data = data[0];
    case (win)
      2'd1:    win_data = data[1];
      2'd2:    win_data = data[2];
      default: win_data = data[0];
    endcase
  end

  assign bus.src0_ready = ready[0];
  assign bus.src1_ready = ready[1];
  assign bus.src2_ready = ready[2];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_sel    = out_sel_q;

  // Output register and arbitration state; a stall leaves everything untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 3'b000;
      ptr         <= 2'd0;
      last_w      <= 2'd0;
      last_v      <= 1'b0;
      cnt         <= 4'd0;
    end else if (can_acc && has_win) begin
      out_valid_q <= 1'b1;
      out_data_q  <= win_data;
      out_sel_q   <= onehot(win);
      if (RR_EN != 0) ptr <= nxt(win);
      if (last_v && (win == last_w)) begin
        cnt <= (cnt < BURST_M1) ? cnt + 4'd1 : cnt;
      end else begin
        cnt <= 4'd0;
      end
      last_w <= win;
      last_v <= 1'b1;
    end else if (can_acc) begin
      out_valid_q <= 1'b0;
      last_v      <= 1'b0;
      cnt         <= 4'd0;
    end
  end
endmodule

// File: tb/tb_sel_rr_arb_32x3.sv
// tb/tb_sel_rr_arb_32x3.sv - self-checking bench for sel_rr_arb_32x3
module tb_sel_rr_arb_32x3;
  localparam logic [31:0] D0 = 32'hA000_0000;
  localparam logic [31:0] D1 = 32'hB111_1111;
  localparam logic [31:0] D2 = 32'hC222_2222;

  typedef struct packed {
    logic [2:0] valid;
    logic       ordy;
    logic [2:0] exp_rdy;
    logic       exp_ov;
    logic [2:0] exp_sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sv;
  logic [31:0] sd [3];
  logic        ordy;
  int          checks = 0;
  int          failures = 0;

  logic [2:0]  rdy  [3];
  logic        ov   [3];
  logic [2:0]  osel [3];
  logic [31:0] odat [3];

  always #5 clk = ~clk;

  // Instance 0: RR burst 1, instance 1: fixed priority, instance 2: RR burst 3; shared stimulus
  sel_rr_arb_32x3_if #(.WIDTH(32)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].src0_valid = sv[0];
    assign bus[g].src1_valid = sv[1];
    assign bus[g].src2_valid = sv[2];
    assign bus[g].src0_data  = sd[0];
    assign bus[g].src1_data  = sd[1];
    assign bus[g].src2_data  = sd[2];
    assign bus[g].out_ready  = ordy;
    assign rdy[g]  = {bus[g].src2_ready, bus[g].src1_ready, bus[g].src0_ready};
    assign ov[g]   = bus[g].out_valid;
    assign osel[g] = bus[g].out_sel;
    assign odat[g] = bus[g].out_data;

    sel_rr_arb_32x3 #(
      .WIDTH(32),
      .RR_EN((g == 1) ? 0 : 1),
      .BURST((g == 2) ? 3 : 1)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .bus(bus[g])
    );
  end

  function automatic vec_t mk(logic [2:0] v, logic r, logic [2:0] er, logic eo, logic [2:0] es);
    vec_t t;
    t.valid = v; t.ordy = r; t.exp_rdy = er; t.exp_ov = eo; t.exp_sel = es;
    return t;
  endfunction

  function automatic logic [31:0] exp_data(logic [2:0] s);
    case (s)
      3'b001:  return D0;
      3'b010:  return D1;
      3'b100:  return D2;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sv = 3'b000;
    ordy = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc();
  endtask

  task automatic run_tbl(input int d, input vec_t t[$], input string tag);
    for (int i = 0; i < t.size(); i++) begin
      sv = t[i].valid;
      ordy = t[i].ordy;
      #1;
      chk({tag, "_rdy"}, i, {29'd0, rdy[d]}, {29'd0, t[i].exp_rdy});
      cyc();
      chk({tag, "_ov"}, i, {31'd0, ov[d]}, {31'd0, t[i].exp_ov});
      chk({tag, "_sel"}, i, {29'd0, osel[d]}, {29'd0, t[i].exp_sel});
      chk({tag, "_data"}, i, odat[d], exp_data(t[i].exp_sel));
    end
  endtask

  initial begin
    vec_t t_rr[$];
    vec_t t_fp[$];
    vec_t t_b3a[$];
    vec_t t_b3b[$];
    logic [31:0] q[$];
    int sent;
    int got;
    int guard;
    logic accepted;

    // RR burst 1: rotation, 4-cycle stall, resume from saved ptr, drain, accept while ordy=0
    for (int i = 0; i < 6; i++) begin
      t_rr.push_back(mk(3'b111, 1'b1, 3'b001 << (i % 3), 1'b1, 3'b001 << (i % 3)));
    end
    for (int i = 0; i < 4; i++) t_rr.push_back(mk(3'b111, 1'b0, 3'b000, 1'b1, 3'b100));
    t_rr.push_back(mk(3'b111, 1'b1, 3'b001, 1'b1, 3'b001));
    t_rr.push_back(mk(3'b000, 1'b1, 3'b000, 1'b0, 3'b001));
    t_rr.push_back(mk(3'b010, 1'b0, 3'b010, 1'b1, 3'b010));
    t_rr.push_back(mk(3'b010, 1'b0, 3'b000, 1'b1, 3'b010));
    // Fixed priority: src0 always, then src1 once src0 drops
    for (int i = 0; i < 3; i++) t_fp.push_back(mk(3'b111, 1'b1, 3'b001, 1'b1, 3'b001));
    t_fp.push_back(mk(3'b110, 1'b1, 3'b010, 1'b1, 3'b010));
    // Burst 3: 0,0,0,1,1,1,2,2,2,0
    for (int i = 0; i < 10; i++) begin
      t_b3a.push_back(mk(3'b111, 1'b1, 3'b001 << ((i / 3) % 3), 1'b1, 3'b001 << ((i / 3) % 3)));
    end
    // Burst 3 broken by src0 dropping after 2 beats; src1 then gets a fresh 3-beat burst
    t_b3b.push_back(mk(3'b111, 1'b1, 3'b001, 1'b1, 3'b001));
    t_b3b.push_back(mk(3'b111, 1'b1, 3'b001, 1'b1, 3'b001));
    t_b3b.push_back(mk(3'b110, 1'b1, 3'b010, 1'b1, 3'b010));
    t_b3b.push_back(mk(3'b111, 1'b1, 3'b010, 1'b1, 3'b010));
    t_b3b.push_back(mk(3'b111, 1'b1, 3'b010, 1'b1, 3'b010));
    t_b3b.push_back(mk(3'b111, 1'b1, 3'b100, 1'b1, 3'b100));

    sd[0] = D0; sd[1] = D1; sd[2] = D2;
    sv = 3'b000; ordy = 1'b1; reset = 1'b1;
    #2;
    chk("rst_ov", 0, {31'd0, ov[0]}, 32'd0);
    chk("rst_sel", 0, {29'd0, osel[0]}, 32'd0);
    chk("rst_data", 0, odat[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // Reset mid-stream while holding a beat
    sv = 3'b111; ordy = 1'b0;
    #1;
    chk("mid_rdy", 0, {29'd0, rdy[0]}, 32'd1);
    cyc();
    chk("mid_ov", 0, {31'd0, ov[0]}, 32'd1);
    chk("mid_sel", 0, {29'd0, osel[0]}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_ov", 1, {31'd0, ov[0]}, 32'd0);
    chk("mid_sel", 1, {29'd0, osel[0]}, 32'd0);
    chk("mid_data", 1, odat[0], 32'd0);
    chk("mid_rdy", 1, {29'd0, rdy[0]}, 32'd0);
    #1;
    reset = 1'b0;
    ordy = 1'b1;
    #1;
    chk("mid_rdy", 2, {29'd0, rdy[0]}, 32'd1);
    cyc();
    chk("mid_sel", 2, {29'd0, osel[0]}, 32'd1);
    chk("mid_data", 2, odat[0], D0);

    do_reset();
    run_tbl(0, t_rr, "rr");
    do_reset();
    run_tbl(1, t_fp, "fp");
    do_reset();
    run_tbl(2, t_b3a, "b3");
    do_reset();
    run_tbl(2, t_b3b, "b3drop");

    // Single source src2 streaming 0..9 under random backpressure
    do_reset();
    sent = 0; got = 0; guard = 0;
    sv = 3'b100; sd[2] = 32'd0;
    while (got < 10 && guard < 400) begin
      ordy = 1'($urandom_range(0, 1));
      #1;
      if (ov[0] && ordy) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra[%0d] got=%h expected=none", got, odat[0]);
        end else begin
          chk("sb_data", got, odat[0], q.pop_front());
        end
        chk("sb_sel", got, {29'd0, osel[0]}, 32'd4);
        got++;
      end
      accepted = sv[2] && rdy[0][2];
      if (accepted) q.push_back(sd[2]);
      cyc();
      if (accepted) begin
        sent++;
        if (sent < 10) sd[2] = 32'(sent);
        else sv = 3'b000;
      end
      guard++;
    end
    chk("sb_count", 0, 32'(got), 32'd10);
    chk("sb_empty", 0, 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
